// File: rtl/mastermind_pkg.sv
// +--------------------------------------------------------------------+
// | mastermind_pkg : shared types and constants for the guess scorer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mastermind_pkg;

  localparam int NUM_PEGS_DEF    = 4;
  localparam int COLOR_BITS_DEF  = 3;
  localparam int MAX_GUESSES_DEF = 10;

  typedef logic [COLOR_BITS_DEF-1:0] color_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    TALLY  = 3'd2,
    REPORT = 3'd3,
    OVER   = 3'd4
  } state_t;

  function automatic color_t peg_at(input logic [NUM_PEGS_DEF*COLOR_BITS_DEF-1:0] code,
                                    input int idx);
    return code[idx*COLOR_BITS_DEF +: COLOR_BITS_DEF];
  endfunction

endpackage

`default_nettype wire

// File: rtl/color_histogram.sv
// +--------------------------------------------------------------------+
// | color_histogram : one counter per colour with clear/inc/read       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module color_histogram #(
  parameter int COLOR_BITS = 3,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  input  logic [COLOR_BITS-1:0] inc_color,
  input  logic [COLOR_BITS-1:0] rd_color,
  output logic [CNT_W-1:0]      rd_count
);

  localparam int NUM_COLORS = 1 << COLOR_BITS;

  logic [CNT_W-1:0] counts [NUM_COLORS];

  for (genvar c = 0; c < NUM_COLORS; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (inc && (inc_color == COLOR_BITS'(c))) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign counts[c] = cnt_q;
  end

  assign rd_count = counts[rd_color];

endmodule

`default_nettype wire

// File: rtl/guess_scorer.sv
// +--------------------------------------------------------------------+
// | guess_scorer : Mastermind exact/partial scoring with game tracking |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module guess_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS    = NUM_PEGS_DEF,
  parameter int COLOR_BITS  = COLOR_BITS_DEF,
  parameter int MAX_GUESSES = MAX_GUESSES_DEF
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic                             new_game,
  input  logic [NUM_PEGS*COLOR_BITS-1:0]   secret,
  input  logic                             submit,
  input  logic [NUM_PEGS*COLOR_BITS-1:0]   guess,
  output logic                             busy,
  output logic                             score_valid,
  output logic [$clog2(NUM_PEGS+1)-1:0]    exact,
  output logic [$clog2(NUM_PEGS+1)-1:0]    partial,
  output logic                             won,
  output logic                             lost,
  output logic                             game_over,
  output logic [$clog2(MAX_GUESSES+1)-1:0] guesses_used
);

  localparam int NUM_COLORS = 1 << COLOR_BITS;
  localparam int CODE_W     = NUM_PEGS * COLOR_BITS;
  localparam int CNT_W      = $clog2(NUM_PEGS + 1);
  localparam int GU_W       = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W      = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;

  state_t                  state_q, state_d;
  logic [CODE_W-1:0]       secret_q, secret_d;
  logic [CODE_W-1:0]       guess_q, guess_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [COLOR_BITS-1:0]   tally_idx_q, tally_idx_d;
  logic [CNT_W-1:0]        exact_acc_q, exact_acc_d;
  logic [CNT_W-1:0]        partial_acc_q, partial_acc_d;
  logic                    busy_q, busy_d;
  logic                    score_valid_q, score_valid_d;
  logic [CNT_W-1:0]        exact_q, exact_d;
  logic [CNT_W-1:0]        partial_q, partial_d;
  logic                    won_q, won_d;
  logic                    lost_q, lost_d;
  logic                    game_over_q, game_over_d;
  logic [GU_W-1:0]         guesses_used_q, guesses_used_d;

  logic                    hist_clear;
  logic                    hist_inc;
  logic [COLOR_BITS-1:0]   sec_peg;
  logic [COLOR_BITS-1:0]   gs_peg;
  logic [CNT_W-1:0]        sec_cnt;
  logic [CNT_W-1:0]        gs_cnt;
  logic [CNT_W-1:0]        min_cnt;
  logic [GU_W-1:0]         used_next;

  assign sec_peg   = secret_q[int'(scan_idx_q)*COLOR_BITS +: COLOR_BITS];
  assign gs_peg    = guess_q[int'(scan_idx_q)*COLOR_BITS +: COLOR_BITS];
  assign min_cnt   = (sec_cnt < gs_cnt) ? sec_cnt : gs_cnt;
  assign used_next = guesses_used_q + GU_W'(1);

  color_histogram #(.COLOR_BITS(COLOR_BITS), .CNT_W(CNT_W)) u_sec_hist (
    .clk       (clk),
    .rst       (Reset),
    .clear     (hist_clear),
    .inc       (hist_inc),
    .inc_color (sec_peg),
    .rd_color  (tally_idx_q),
    .rd_count  (sec_cnt)
  );

  color_histogram #(.COLOR_BITS(COLOR_BITS), .CNT_W(CNT_W)) u_gs_hist (
    .clk       (clk),
    .rst       (Reset),
    .clear     (hist_clear),
    .inc       (hist_inc),
    .inc_color (gs_peg),
    .rd_color  (tally_idx_q),
    .rd_count  (gs_cnt)
  );

  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    guess_d        = guess_q;
    scan_idx_d     = scan_idx_q;
    tally_idx_d    = tally_idx_q;
    exact_acc_d    = exact_acc_q;
    partial_acc_d  = partial_acc_q;
    exact_d        = exact_q;
    partial_d      = partial_q;
    game_over_d    = game_over_q;
    guesses_used_d = guesses_used_q;
    score_valid_d  = 1'b0;
    won_d          = 1'b0;
    lost_d         = 1'b0;
    hist_clear     = 1'b0;
    hist_inc       = 1'b0;

    if (new_game) begin
      secret_d       = secret;
      guesses_used_d = '0;
      game_over_d    = 1'b0;
      state_d        = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (submit) begin
            guess_d       = guess;
            exact_acc_d   = '0;
            partial_acc_d = '0;
            hist_clear    = 1'b1;
            scan_idx_d    = '0;
            state_d       = SCAN;
          end
        end
        SCAN: begin
          // Only unmatched pegs feed the histograms, so TALLY yields partials directly.
          if (sec_peg == gs_peg) begin
            exact_acc_d = exact_acc_q + CNT_W'(1);
          end else begin
            hist_inc = 1'b1;
          end
          if (scan_idx_q == IDX_W'(NUM_PEGS - 1)) begin
            tally_idx_d = '0;
            state_d     = TALLY;
          end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end
        TALLY: begin
          partial_acc_d = partial_acc_q + min_cnt;
          if (tally_idx_q == COLOR_BITS'(NUM_COLORS - 1)) begin
            state_d = REPORT;
          end else begin
            tally_idx_d = tally_idx_q + COLOR_BITS'(1);
          end
        end
        REPORT: begin
          exact_d        = exact_acc_q;
          partial_d      = partial_acc_q;
          score_valid_d  = 1'b1;
          guesses_used_d = used_next;
          if (exact_acc_q == CNT_W'(NUM_PEGS)) begin
            won_d = 1'b1;
          end else if (used_next == GU_W'(MAX_GUESSES)) begin
            lost_d = 1'b1;
          end
          if (won_d || lost_d) begin
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            state_d = IDLE;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Busy spans the score_valid cycle so it drops one cycle after the result.
    busy_d = (state_d == SCAN) || (state_d == TALLY) || (state_d == REPORT) || score_valid_d;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      secret_q       <= '0;
      guess_q        <= '0;
      scan_idx_q     <= '0;
      tally_idx_q    <= '0;
      exact_acc_q    <= '0;
      partial_acc_q  <= '0;
      busy_q         <= 1'b0;
      score_valid_q  <= 1'b0;
      exact_q        <= '0;
      partial_q      <= '0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
      game_over_q    <= 1'b0;
      guesses_used_q <= '0;
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      guess_q        <= guess_d;
      scan_idx_q     <= scan_idx_d;
      tally_idx_q    <= tally_idx_d;
      exact_acc_q    <= exact_acc_d;
      partial_acc_q  <= partial_acc_d;
      busy_q         <= busy_d;
      score_valid_q  <= score_valid_d;
      exact_q        <= exact_d;
      partial_q      <= partial_d;
      won_q          <= won_d;
      lost_q         <= lost_d;
      game_over_q    <= game_over_d;
      guesses_used_q <= guesses_used_d;
    end
  end

  assign busy         = busy_q;
  assign score_valid  = score_valid_q;
  assign exact        = exact_q;
  assign partial      = partial_q;
  assign won          = won_q;
  assign lost         = lost_q;
  assign game_over    = game_over_q;
  assign guesses_used = guesses_used_q;

endmodule

`default_nettype wire

// File: tb/tb_guess_scorer.sv
// +--------------------------------------------------------------------+
// | tb_guess_scorer : randomized + directed bench with game-level model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_guess_scorer;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        new_game = 1'b0;
  logic [11:0] secret = '0;
  logic        submit = 1'b0;
  logic [11:0] guess = '0;
  logic        busy, score_valid, won, lost, game_over;
  logic [2:0]  exact, partial;
  logic [3:0]  guesses_used;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  guess_scorer dut (
    .clk          (clk),
    .Reset        (Reset),
    .new_game     (new_game),
    .secret       (secret),
    .submit       (submit),
    .guess        (guess),
    .busy         (busy),
    .score_valid  (score_valid),
    .exact        (exact),
    .partial      (partial),
    .won          (won),
    .lost         (lost),
    .game_over    (game_over),
    .guesses_used (guesses_used)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mastermind rule: partial = sum over colours of min(occurrences) minus exact.
  function automatic void score(input logic [11:0] s, input logic [11:0] g,
                                output int ex, output int pa);
    int cs[8];
    int cg[8];
    int tot;
    logic [11:0] sv, gv;
    sv = s; gv = g;
    ex = 0; tot = 0;
    for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (sv[i*3 +: 3] == gv[i*3 +: 3]) ex++;
      cs[sv[i*3 +: 3]]++;
      cg[gv[i*3 +: 3]]++;
    end
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    pa = tot - ex;
  endfunction

  // Game-level model: a scored guess emerges exactly 13 cycles after acceptance.
  logic [11:0] m_secret = '0;
  int m_busy = 0, m_sv = 0, m_exact = 0, m_partial = 0, m_won = 0, m_lost = 0;
  int m_over = 0, m_used = 0, m_inflight = 0, m_cnt = 0, p_ex = 0, p_pa = 0;

  always @(posedge clk) begin
    if (Reset) begin
      m_secret = '0; m_busy = 0; m_sv = 0; m_exact = 0; m_partial = 0;
      m_won = 0; m_lost = 0; m_over = 0; m_used = 0; m_inflight = 0;
    end else if (new_game) begin
      m_secret = secret; m_used = 0; m_over = 0; m_inflight = 0;
      m_busy = 0; m_sv = 0; m_won = 0; m_lost = 0;
    end else begin
      m_sv = 0; m_won = 0; m_lost = 0;
      if (m_inflight != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_inflight = 0;
          m_sv = 1;
          m_exact = p_ex;
          m_partial = p_pa;
          m_used++;
          if (p_ex == 4) m_won = 1;
          else if (m_used == 10) m_lost = 1;
          if (m_won != 0 || m_lost != 0) m_over = 1;
        end
      end else begin
        m_busy = 0;
        if (submit && m_over == 0) begin
          m_inflight = 1;
          m_cnt = 13;
          score(m_secret, guess, p_ex, p_pa);
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), m_busy);
      check("score_valid", int'(score_valid), m_sv);
      check("exact", int'(exact), m_exact);
      check("partial", int'(partial), m_partial);
      check("won", int'(won), m_won);
      check("lost", int'(lost), m_lost);
      check("game_over", int'(game_over), m_over);
      check("guesses_used", int'(guesses_used), m_used);
      if (int'(exact) + int'(partial) > 4) check("exact_plus_partial", int'(exact) + int'(partial), 4);
    end
  end

  task automatic step(input logic ng, input logic [11:0] s, input logic sb,
                      input logic [11:0] g, input logic r);
    new_game = ng; secret = s; submit = sb; guess = g; Reset = r;
    @(negedge clk);
    new_game = 1'b0; submit = 1'b0; Reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_score(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (score_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("score_timeout", 0, 1);
  endtask

  int lat, ex, pa, sv_seen;
  logic [11:0] s, g;

  initial begin
    // Pin the scoring function with hand-computed values.
    score({3'd4, 3'd3, 3'd2, 3'd1}, {3'd4, 3'd3, 3'd2, 3'd1}, ex, pa);
    check("model_exact_win", ex, 4); check("model_partial_win", pa, 0);
    score({3'd1, 3'd2, 3'd3, 3'd4}, {3'd4, 3'd3, 3'd2, 3'd1}, ex, pa);
    check("model_exact_perm", ex, 0); check("model_partial_perm", pa, 4);
    score({3'd1, 3'd1, 3'd2, 3'd2}, {3'd1, 3'd2, 3'd1, 3'd1}, ex, pa);
    check("model_exact_dup", ex, 1); check("model_partial_dup", pa, 2);

    idle(2);
    chk_en = 1'b1;
    Reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_guesses", int'(guesses_used), 0);
    check("rst_exact", int'(exact), 0);

    // 1: immediate win
    step(1, {3'd4, 3'd3, 3'd2, 3'd1}, 0, '0, 0);
    step(0, '0, 1, {3'd4, 3'd3, 3'd2, 3'd1}, 0);
    check("t1_busy_rise", int'(busy), 1);
    wait_score(lat);
    check("t1_latency", lat, 13);
    check("t1_exact", int'(exact), 4);
    check("t1_partial", int'(partial), 0);
    check("t1_won", int'(won), 1);
    check("t1_used", int'(guesses_used), 1);
    check("t1_game_over", int'(game_over), 1);
    check("t1_busy_during_valid", int'(busy), 1);
    idle(1);
    check("t1_won_pulse", int'(won), 0);
    check("t1_busy_fall", int'(busy), 0);

    // 2: full permutation
    step(1, {3'd1, 3'd2, 3'd3, 3'd4}, 0, '0, 0);
    step(0, '0, 1, {3'd4, 3'd3, 3'd2, 3'd1}, 0);
    wait_score(lat);
    check("t2_exact", int'(exact), 0);
    check("t2_partial", int'(partial), 4);
    check("t2_won", int'(won), 0);
    check("t2_lost", int'(lost), 0);
    check("t2_game_over", int'(game_over), 0);

    // 3: duplicates
    step(1, {3'd1, 3'd1, 3'd2, 3'd2}, 0, '0, 0);
    step(0, '0, 1, {3'd1, 3'd2, 3'd1, 3'd1}, 0);
    wait_score(lat);
    check("t3_exact", int'(exact), 1);
    check("t3_partial", int'(partial), 2);
    idle(1);

    // 4: ten misses lose the game
    s = 12'($urandom);
    step(1, s, 0, '0, 0);
    for (int n = 1; n <= 10; n++) begin
      g = 12'($urandom);
      if (g == s) g = s ^ 12'h001;
      step(0, '0, 1, g, 0);
      wait_score(lat);
      idle(1);
    end
    check("t4_lost_level_after", int'(game_over), 1);
    check("t4_used", int'(guesses_used), 10);
    step(0, '0, 1, s, 0);
    check("t4_ignored_busy", int'(busy), 0);
    idle(3);
    check("t4_ignored_busy_later", int'(busy), 0);

    // 5: second submit ignored, new_game aborts
    step(1, {3'd7, 3'd0, 3'd5, 3'd5}, 0, '0, 0);
    step(0, '0, 1, {3'd5, 3'd5, 3'd0, 3'd7}, 0);
    idle(1);
    step(0, '0, 1, {3'd7, 3'd0, 3'd5, 3'd5}, 0);
    idle(2);
    step(1, {3'd7, 3'd0, 3'd5, 3'd5}, 0, '0, 0);
    check("t5_busy_low", int'(busy), 0);
    sv_seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (score_valid) sv_seen = 1;
    end
    check("t5_no_score", sv_seen, 0);
    check("t5_used", int'(guesses_used), 0);

    // 6: reset during TALLY
    step(0, '0, 1, {3'd7, 3'd0, 3'd5, 3'd1}, 0);
    idle(7);
    step(0, '0, 0, '0, 1);
    check("t6_busy", int'(busy), 0);
    check("t6_exact", int'(exact), 0);
    check("t6_partial", int'(partial), 0);
    check("t6_used", int'(guesses_used), 0);
    step(1, {3'd2, 3'd6, 3'd6, 3'd3}, 0, '0, 0);
    step(0, '0, 1, {3'd6, 3'd6, 3'd2, 3'd3}, 0);
    wait_score(lat);
    check("t6_exact_after", int'(exact), 2);
    check("t6_partial_after", int'(partial), 2);

    // Randomized phase, the model checks every cycle.
    s = 12'($urandom);
    step(1, s, 0, '0, 0);
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      g = 12'($urandom);
      if ($urandom_range(0, 3) == 0) g = s;
      else if ($urandom_range(0, 2) == 0) g = {g[5:0], s[5:0]};
      if (r < 2) begin
        s = 12'($urandom);
        step(1, s, ($urandom_range(0, 1) == 1), g, 0);
      end else if (r < 3) begin
        step(0, '0, 0, '0, 1);
        s = '0;
      end else if (r < 30) begin
        step(0, '0, 1, g, 0);
      end else begin
        step(0, '0, 0, '0, 0);
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
